// File: rtl/bullet_bill_ctrl.sv
// bullet_bill_ctrl
//   Game-state stage that owns the three Bullet Bill slots. A fire pulse
//   spawns a bullet at the player's X. Each game tick steps every live bullet
//   one row upward. A bullet at the top row despawns. A collision with an
//   occupied DDaver cell is reported to the grid controller over a
//   valid/ready handshake.
//
//   Optional feature: define BULLET_SCORE_EN to add a saturating 8-bit
//   score output that counts accepted hits.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              one-cycle game-step pulse
//   fire, fire_color  one-cycle fire pulse and bullet colour (0 = ignored)
//   blockPos          Blockieee X position, used as the spawn X
//   ddState           DDaver grid, [row][col], 0 = empty cell
//   hit_ready         grid controller accepts the pending hit
//   bullState/X/Y     per-slot colour (0 = empty) and position
//   hit_valid         collision pending
//   hit_row, hit_col  grid cell of the collision
//   hit_color         colour of the colliding bullet
//   busy              controller is walking slots or waiting on a hit
//   fire_drop         one-cycle pulse: a fire was lost because all slots were full
//   score             (BULLET_SCORE_EN only) accepted-hit count, saturates at 255
module bullet_bill_ctrl #(
  parameter int SPAWN_Y   = 14,
  parameter int GRID_ROWS = 5,
  parameter int GRID_COLS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       fire,
  input  logic [1:0] fire_color,
  input  logic [3:0] blockPos,
  input  logic [2:0] ddState [0:GRID_ROWS-1][0:GRID_COLS-1],
  input  logic       hit_ready,
  output logic [1:0] bullState [0:2],
  output logic [3:0] bullX [0:2],
  output logic [3:0] bullY [0:2],
  output logic       hit_valid,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic [1:0] hit_color,
  output logic       busy,
  output logic       fire_drop
`ifdef BULLET_SCORE_EN
  ,
  output logic [7:0] score
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_HIT} state_t;

  state_t     state_reg;
  logic [1:0] idx_reg;
  logic       tick_pend_reg;
  logic       fire_pend_reg;
  logic [1:0] fire_color_reg;
  logic [3:0] fire_x_reg;

  // Slot currently addressed by the MOVE/HIT walk.
  logic [1:0] cur_state;
  logic [3:0] cur_x;
  logic [3:0] cur_y;
  logic [3:0] new_y;
  logic       cell_hit;
  logic       move_hit;
  logic       free_found;
  logic [1:0] free_idx;

  assign cur_state = bullState[idx_reg];
  assign cur_x     = bullX[idx_reg];
  assign cur_y     = bullY[idx_reg];
  assign new_y     = cur_y - 4'd1;

  // Matching row/col against loop constants keeps every grid index in range,
  // so an off-grid bullet can never read outside ddState.
  always_comb begin
    cell_hit = 1'b0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (new_y == 4'(r) && cur_x == 4'(c) && ddState[r][c] != 3'd0)
          cell_hit = 1'b1;
      end
    end
  end

  // Only a live bullet that actually steps (Y != 0) can collide.
  assign move_hit = (cur_state != 2'd0) && (cur_y != 4'd0) && cell_hit;

  // Lowest-index empty slot: scan high to low so the lowest one wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (bullState[i] == 2'd0) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  assign busy = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 2'd0;
      tick_pend_reg  <= 1'b0;
      fire_pend_reg  <= 1'b0;
      fire_color_reg <= 2'd0;
      fire_x_reg     <= 4'd0;
      for (int i = 0; i < 3; i++) begin
        bullState[i] <= 2'd0;
        bullX[i]     <= 4'd0;
        bullY[i]     <= 4'd0;
      end
      hit_valid <= 1'b0;
      hit_row   <= 3'd0;
      hit_col   <= 3'd0;
      hit_color <= 2'd0;
      fire_drop <= 1'b0;
`ifdef BULLET_SCORE_EN
      score     <= 8'd0;
`endif
    end else begin
      fire_drop <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // Movement has priority, so a bullet spawned alongside a tick is
          // placed only after that tick's walk and is not stepped by it.
          if (tick_pend_reg) begin
            tick_pend_reg <= 1'b0;
            idx_reg       <= 2'd0;
            state_reg     <= ST_MOVE;
          end else if (fire_pend_reg) begin
            fire_pend_reg <= 1'b0;
            if (free_found) begin
              bullState[free_idx] <= fire_color_reg;
              bullX[free_idx]     <= fire_x_reg;
              bullY[free_idx]     <= 4'(SPAWN_Y);
            end else begin
              fire_drop <= 1'b1;
            end
          end
        end

        ST_MOVE: begin
          if (cur_state != 2'd0) begin
            if (cur_y == 4'd0) begin
              bullState[idx_reg] <= 2'd0;
              bullX[idx_reg]     <= 4'd0;
              bullY[idx_reg]     <= 4'd0;
            end else begin
              bullY[idx_reg] <= new_y;
            end
          end
          if (move_hit) begin
            hit_valid <= 1'b1;
            hit_row   <= new_y[2:0];
            hit_col   <= cur_x[2:0];
            hit_color <= cur_state;
            state_reg <= ST_HIT;
          end else if (idx_reg == 2'd2) begin
            state_reg <= ST_IDLE;
          end else begin
            idx_reg <= idx_reg + 2'd1;
          end
        end

        ST_HIT: begin
          // hit_valid is always high in this state, so only ready is needed.
          if (hit_ready) begin
            bullState[idx_reg] <= 2'd0;
            bullX[idx_reg]     <= 4'd0;
            bullY[idx_reg]     <= 4'd0;
            hit_valid          <= 1'b0;
            hit_row            <= 3'd0;
            hit_col            <= 3'd0;
            hit_color          <= 2'd0;
`ifdef BULLET_SCORE_EN
            if (score != 8'hFF)
              score <= score + 8'd1;
`endif
            if (idx_reg == 2'd2) begin
              state_reg <= ST_IDLE;
            end else begin
              idx_reg   <= idx_reg + 2'd1;
              state_reg <= ST_MOVE;
            end
          end
        end

        default: state_reg <= ST_IDLE;
      endcase

      // New arrivals are applied last so they win over a same-cycle clear.
      if (tick)
        tick_pend_reg <= 1'b1;
      if (fire && fire_color != 2'd0) begin
        fire_pend_reg  <= 1'b1;
        fire_color_reg <= fire_color;
        fire_x_reg     <= blockPos;
      end
    end
  end

endmodule
